// File: rtl/ps2_scode_evt_if.sv
// Event output bus of the PS/2 scan-code event decoder.
//   evt_code  : code byte of the FIFO head (0 when empty)
//   evt_ext   : head event carried the extended prefix
//   evt_brk   : head event is a key release
//   evt_valid : FIFO non-empty
//   evt_ready : consumer accepts the head when evt_valid is also high
// master = event producer (decoder), slave = event consumer.
interface ps2_scode_evt_if;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_valid;
    logic       evt_ready;

    modport master (
        output evt_code,
        output evt_ext,
        output evt_brk,
        output evt_valid,
        input  evt_ready
    );

    modport slave (
        input  evt_code,
        input  evt_ext,
        input  evt_brk,
        input  evt_valid,
        output evt_ready
    );
endinterface

// File: rtl/ps2_scode_evt.sv
// PS/2 set-2 scan-code event decoder.
// Tracks the extended (E0) and break (F0) prefixes in the received byte stream and queues
// one tagged event {ext, brk, code} per key action into a show-ahead FIFO.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   scode     : received scan-code byte, qualified by scode_en (one-cycle strobe)
//   evt       : event output bus (head of FIFO, valid/ready handshake)
//   evt_cnt   : current FIFO occupancy
//   err       : sticky flags {overflow, bad prefix order, double E0, double F0}
//   err_clr   : clears err; an error raised in the same cycle still sets its bit
module ps2_scode_evt #(
    parameter logic [7:0]  BREAK_CODE = 8'hF0,
    parameter logic [7:0]  EXT_CODE   = 8'hE0,
    parameter bit          EMIT_BREAK = 1'b1,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            scode,
    input  logic                  scode_en,
    ps2_scode_evt_if.master       evt,
    output logic [CntW-1:0]       evt_cnt,
    output logic [3:0]            err,
    input  logic                  err_clr
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e          state_q, state_d;
    logic [9:0]      mem_q [DEPTH];
    logic [9:0]      mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      err_q, err_d;

    logic            push;
    logic            push_ext;
    logic            push_brk;
    logic [2:0]      seq_err;
    logic            empty;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            overflow;
    logic [9:0]      head;

    // Prefix decoder
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_ext = 1'b0;
        push_brk = 1'b0;
        seq_err  = 3'b000;
        if (scode_en) begin
            case (state_q)
                StIdle: begin
                    if (scode == EXT_CODE) begin
                        state_d = StExt;
                    end else if (scode == BREAK_CODE) begin
                        state_d = StBrk;
                    end else begin
                        push = 1'b1;
                    end
                end
                StExt: begin
                    if (scode == BREAK_CODE) begin
                        state_d = StExtBrk;
                    end else if (scode == EXT_CODE) begin
                        seq_err[1] = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StBrk: begin
                    if (scode == BREAK_CODE) begin
                        seq_err[0] = 1'b1;
                    end else if (scode == EXT_CODE) begin
                        seq_err[2] = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        push     = EMIT_BREAK;
                        push_brk = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StExtBrk: begin
                    if (scode == BREAK_CODE || scode == EXT_CODE) begin
                        seq_err[2] = 1'b1;
                    end else begin
                        push     = EMIT_BREAK;
                        push_ext = 1'b1;
                        push_brk = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Event FIFO
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CntW'(DEPTH));
    assign pop      = !empty && evt.evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en    = push && (!full || pop);
    assign overflow = push && full && !pop;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {push_ext, push_brk, scode};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Sticky errors; a clear still lets this cycle's new errors through.
    always_comb begin
        err_d = err_clr ? 4'b0000 : err_q;
        err_d = err_d | {overflow, seq_err};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign evt.evt_valid = !empty;
    assign evt.evt_code  = empty ? 8'h00 : head[7:0];
    assign evt.evt_brk   = empty ? 1'b0 : head[8];
    assign evt.evt_ext   = empty ? 1'b0 : head[9];
    assign evt_cnt       = cnt_q;
    assign err           = err_q;

endmodule

// File: doc/ps2_scode_evt.md
# ps2_scode_evt

PS/2 scan-code event decoder, parametrised successor to the make-only break-code filter.
- Consumes the byte stream from the PS/2 receive path and tracks the set-2 `E0` extended prefix and `F0` break prefix.
- Emits one tagged event per key action (code, extended flag, break flag) into an internal FIFO with a valid/ready output.
- Reports sequence violations and overflow in sticky error flags.
- Sits between the PS/2 byte receiver and the key-mapping / host-interface logic.

## Interface
Parameters:
- `BREAK_CODE`, 8'hF0: break prefix byte.
- `EXT_CODE`, 8'hE0: extended prefix byte.
- `EMIT_BREAK`, 1: 1 = break events are queued with `evt_brk`=1; 0 = break sequences are consumed silently (make-only mode).
- `DEPTH`, 4: event FIFO depth; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `scode` in 8: received scan-code byte.
- `scode_en` in 1: one-cycle strobe; `scode` is valid this cycle.
- `evt_code` out 8: code byte of the FIFO head; 0 when empty.
- `evt_ext` out 1: head event was `EXT_CODE`-prefixed; 0 when empty.
- `evt_brk` out 1: head event is a break (key release); 0 when empty.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: consumer accepts the head when `evt_valid` && `evt_ready`.
- `evt_cnt` out $clog2(DEPTH+1): current FIFO occupancy.
- `err` out 4: sticky error flags, defined below.
- `err_clr` in 1: clears all `err` bits.

## Operation
- Bytes are processed only in cycles where `scode_en`=1. `scode` is ignored otherwise.
- Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - Other byte → push make {ext=0, brk=0, code}; stay IDLE.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → set err[1]; stay EXT.
    - Other byte → push make {ext=1, brk=0}; → IDLE.
  - BRK:
    - F0 → set err[0]; stay BRK.
    - E0 → set err[2]; → IDLE; no push.
    - Other byte → push {ext=0, brk=1} if EMIT_BREAK, else no push; → IDLE.
  - EXT_BRK:
    - E0 or F0 → set err[2]; → IDLE; no push.
    - Other byte → push {ext=1, brk=1} if EMIT_BREAK, else no push; → IDLE.
- Typematic repeats, i.e. repeated make bytes in IDLE, each produce an event.
- FIFO:
  - 10-bit entries {ext, brk, code}; show-ahead, so the head is always on the outputs.
  - Pop occurs when `evt_valid` && `evt_ready`.
  - Push while full with no pop in the same cycle: the new event is dropped and err[3] is set. Stored entries are unchanged.
  - Push and pop in the same cycle while full: the push is accepted and occupancy is unchanged.
  - Push and pop in the same cycle while empty: not applicable. The push lands at cycle end and no pop occurs, because `evt_valid` was 0.
  - Pointers wrap modulo DEPTH.
- Error flags:
  - err[0]: double break prefix.
  - err[1]: double extended prefix.
  - err[2]: illegal prefix order.
  - err[3]: FIFO overflow.
  - Bits are sticky until `err_clr`.
  - If `err_clr` and a new error occur in the same cycle, the new error bit is set and all other bits clear.

## Timing
- Reset values:
  - state = IDLE.
  - FIFO empty, `evt_cnt`=0.
  - `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_brk`=0.
  - `err`=0.
- Reset mid-sequence (e.g. after E0) discards the pending prefix. The next byte is decoded from IDLE.
- Latency: a terminating byte with `scode_en` at cycle N gives `evt_valid`=1 with the event on the outputs at cycle N+1 (FIFO previously empty).
- Pop at cycle N: the next head, or zeros if empty, appears at N+1. `evt_cnt` updates at N+1.
- Throughput: one event per cycle in and one per cycle out. `scode_en` may be asserted on consecutive cycles.
- Error bits assert the cycle after the offending byte.

## Test plan
- Make only: `scode_en` with 8'h1C, `evt_ready`=1 → one cycle later `evt_valid`=1, code=1C, ext=0, brk=0; empty the next cycle.
- Break, EMIT_BREAK=1: bytes 1C, F0, 1C → two events, {1C,0,0} then {1C,0,1}. Same sequence with EMIT_BREAK=0 → only {1C,0,0}.
- Extended: E0 75, E0 F0 75 → {75,1,0} then {75,1,1}; `err`=0.
- Errors: F0 F0 1C → err[0]=1 and event {1C,0,1}. E0 E0 → err[1]. F0 E0 → err[2] and no event. Then `err_clr` → `err`=0.
- Overflow, DEPTH=4, `evt_ready`=0: makes 01..05 → `evt_cnt`=4, err[3]=1, drain order 01,02,03,04. Full plus simultaneous push and pop → `evt_cnt` stays 4.
- Reset: E0 then `rst` pulse, then 1C → event {1C,0,0}. Reset with the FIFO holding 3 entries → `evt_valid`=0, `evt_cnt`=0 the next cycle.
